i2c_mem_slave: RTL and testbench
================================

# i2c_mem_slave

I2C responder that fronts the on-chip memory: detects START/STOP on the bus, matches the 8-bit device id, takes a memory address, then either returns one byte read from memory or writes one byte into memory. It is the far end of the APB-driven I2C master, sits between `I2C_Bus` and `I2C_Memory_Bus`, and exports its state on the `I2C_test_signals` debug lines.

## Interface
- No parameters; bus widths fixed at 8 bits.
- `clk8x` in 1: system clock, 8x SCL rate; all logic on rising edge. `reset` in 1: synchronous, active-high.
- `id` in 8: this device's address.
- `scl` in 1: bus clock from master.
- `sda_in` in 1: resolved SDA level. `sda_out` out 1: value driven when enabled (always 0 when enabled). `sda_oe` out 1: 1 = pull SDA low.
- `mem_ce`, `mem_rden`, `mem_wren` out 1 each: memory strobes, single-cycle pulses.
- `mem_addr` out 8, `mem_wdata` out 8, `mem_rdata` in 8 (valid one cycle after `mem_rden`).
- `slave_state` out 4, `slave_data` out 8, `slave_mem_address` out 8, `slave_select` out 8: debug.

## Operation
- Frame: START, 8 id bits MSB first, R/W bit (1 = read), slave ACK, 8 memory-address bits, slave ACK, 8 data bits, ACK (master on read, slave on write), STOP. Single byte per frame.
- START = SDA falls while SCL high; STOP = SDA rises while SCL high. Data sampled on SCL rising edge; slave changes SDA on SCL falling edge.
- States: IDLE, DEV_ADDR, RW, ACK_DEV, MEM_ADDR, ACK_ADDR, RD_DATA, ACK_MASTER, WR_DATA, ACK_WR, WAIT_STOP.
- IDLE -START-> DEV_ADDR -8 bits-> RW -> ACK_DEV if shifted id == `id`, else WAIT_STOP with SDA released (no ACK, no memory access).
- ACK_DEV -> MEM_ADDR -8 bits-> ACK_ADDR -> RD_DATA (read) or WR_DATA (write).
- RD_DATA shifts out `mem_rdata` MSB first -> ACK_MASTER; ACK or NACK both -> WAIT_STOP.
- WR_DATA shifts in 8 bits -> ACK_WR -> WAIT_STOP.
- STOP in any state -> IDLE, SDA released. START in any non-IDLE state (repeated start) -> DEV_ADDR, bit counter cleared.
- `slave_select` = captured id, `slave_mem_address` = captured address, `slave_data` = read/write shift register, `slave_state` = state encoding.

## Timing
- Reset: state IDLE; all outputs 0; shift registers and counters 0.
- SCL/SDA registered once; edges detected by comparing live inputs with registered copies, so edge actions occur the `clk8x` cycle after the edge is seen.
- ACK: `sda_oe` rises on the SCL falling edge that ends the last bit and falls on the next SCL falling edge.
- Read: one-cycle `mem_ce`+`mem_rden` pulse with `mem_addr` on the cycle after the 8th address bit is sampled; `mem_rdata` latched into `slave_data` the next cycle. MSB driven from the falling edge that ends ACK_ADDR. On `sda_oe`, 1 bits = released, 0 bits = pulled low.
- Write: one-cycle `mem_ce`+`mem_wren` pulse with `mem_addr`/`mem_wdata` on the cycle after the 8th data bit is sampled.
- Memory strobes never fire outside these two cycles.
- Simultaneous STOP/START and bit sample in one cycle: STOP/START wins.
- `reset` mid-frame: `sda_oe` 0 on the next edge.

## Structure
- `i2c_pkg`: `slave_state_t` enum (4-bit, values above), `I2C_BYTE_W = 8`, `I2C_READ = 1'b1`.
- Sub-module `i2c_line_sampler`: registers SCL/SDA and emits `scl_rise`, `scl_fall`, `start_det`, `stop_det` pulses. FSM, counters and shift registers stay in `i2c_mem_slave`.

## Test plan
- `id`=0x01, memory mem[i]=i; read id 0x01, address 0x05 -> ACK twice, one `mem_rden` pulse at addr 0x05, SDA serializes 0x05; after STOP, `slave_state` = IDLE.
- Write 0xA5 to 0x10 at id 0x01 -> three slave ACKs, one `mem_wren` pulse with `mem_addr` 0x10 and `mem_wdata` 0xA5; a following read of 0x10 returns 0xA5.
- Frame to id 0x02 -> `sda_oe` stays 0 for the whole frame, no memory strobes, WAIT_STOP then IDLE.
- STOP after 3 address bits -> IDLE the cycle after detection, no strobes; the next full read succeeds.
- Repeated START after ACK_ADDR of a write, then a read frame -> no `mem_wren` pulse; the read returns the correct byte.
- `reset` asserted during RD_DATA with `sda_oe`=1 -> all outputs 0 and IDLE on the next edge.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C memory responder.
// State encoding is exported on the debug port, so its values are fixed.
package i2c_pkg;

    localparam int   I2C_BYTE_W = 8;
    localparam logic I2C_READ   = 1'b1;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        DEV_ADDR   = 4'd1,
        RW         = 4'd2,
        ACK_DEV    = 4'd3,
        MEM_ADDR   = 4'd4,
        ACK_ADDR   = 4'd5,
        RD_DATA    = 4'd6,
        ACK_MASTER = 4'd7,
        WR_DATA    = 4'd8,
        ACK_WR     = 4'd9,
        WAIT_STOP  = 4'd10
    } slave_state_t;

endpackage

// File: rtl/i2c_line_sampler.sv
// Registers SCL/SDA once and flags bus edges and START/STOP conditions.
// Pulses are valid in the cycle the live level differs from the copy.
module i2c_line_sampler (
    input  logic clk8x_i,
    input  logic reset_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic scl_q;
    logic sda_q;

    // Reset to the idle-bus level so leaving reset creates no false edge
    always_ff @(posedge clk8x_i) begin
        if (reset_i) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_i;
            sda_q <= sda_i;
        end
    end

    assign scl_rise_o  = scl_i & ~scl_q;
    assign scl_fall_o  = ~scl_i & scl_q;
    assign start_det_o = scl_i & scl_q & sda_q & ~sda_i;
    assign stop_det_o  = scl_i & scl_q & ~sda_q & sda_i;

endmodule

// File: rtl/i2c_mem_slave.sv
// I2C responder in front of the on-chip memory: one byte per frame,
// device id match, 8-bit memory address, single read or write.
module i2c_mem_slave
    import i2c_pkg::*;
(
    input  logic       clk8x,
    input  logic       reset,
    input  logic [7:0] id,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe,
    output logic       mem_ce,
    output logic       mem_rden,
    output logic       mem_wren,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [3:0] slave_state,
    output logic [7:0] slave_data,
    output logic [7:0] slave_mem_address,
    output logic [7:0] slave_select
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_line_sampler u_sampler (
        .clk8x_i     (clk8x),
        .reset_i     (reset),
        .scl_i       (scl),
        .sda_i       (sda_in),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det)
    );

    slave_state_t          state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [I2C_BYTE_W-1:0] sel_q, sel_d;
    logic [I2C_BYTE_W-1:0] addr_q, addr_d;
    logic [I2C_BYTE_W-1:0] data_q, data_d;
    logic [I2C_BYTE_W-1:0] maddr_q, maddr_d;
    logic [I2C_BYTE_W-1:0] wdata_q, wdata_d;
    logic                  rw_q, rw_d;
    logic                  oe_q, oe_d;
    logic                  ce_q, ce_d;
    logic                  rden_q, rden_d;
    logic                  wren_q, wren_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [2:0]            rd_idx;

    assign rd_idx = 3'd7 - cnt_q[2:0];

    always_ff @(posedge clk8x) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            maddr_q   <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            oe_q      <= 1'b0;
            ce_q      <= 1'b0;
            rden_q    <= 1'b0;
            wren_q    <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            maddr_q   <= maddr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            oe_q      <= oe_d;
            ce_q      <= ce_d;
            rden_q    <= rden_d;
            wren_q    <= wren_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        data_d    = data_q;
        maddr_d   = maddr_q;
        wdata_d   = wdata_q;
        rw_d      = rw_q;
        oe_d      = oe_q;
        ce_d      = 1'b0;
        rden_d    = 1'b0;
        wren_d    = 1'b0;
        rd_pend_d = rden_q;

        // Read data is valid the cycle after the strobe; capture it then
        if (rd_pend_q) begin
            data_d = mem_rdata;
        end

        if (stop_det) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            cnt_d   = '0;
        end else if (start_det) begin
            state_d = DEV_ADDR;
            oe_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                DEV_ADDR: begin
                    if (scl_rise) begin
                        sel_d = {sel_q[6:0], sda_in};
                        if (cnt_q == 4'd7) begin
                            state_d = RW;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                RW: begin
                    // cnt marks that the R/W bit itself has been sampled
                    if (scl_rise) begin
                        rw_d  = sda_in;
                        cnt_d = 4'd1;
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d = '0;
                        if (sel_q == id) begin
                            state_d = ACK_DEV;
                            oe_d    = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                            oe_d    = 1'b0;
                        end
                    end
                end
                ACK_DEV: begin
                    if (scl_fall) begin
                        state_d = MEM_ADDR;
                        oe_d    = 1'b0;
                    end
                end
                MEM_ADDR: begin
                    if (scl_rise && !cnt_q[3]) begin
                        addr_d = {addr_q[6:0], sda_in};
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd8;
                            if (rw_q == I2C_READ) begin
                                ce_d    = 1'b1;
                                rden_d  = 1'b1;
                                maddr_d = {addr_q[6:0], sda_in};
                            end
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        state_d = ACK_ADDR;
                        oe_d    = 1'b1;
                        cnt_d   = '0;
                    end
                end
                ACK_ADDR: begin
                    if (scl_fall) begin
                        if (rw_q == I2C_READ) begin
                            state_d = RD_DATA;
                            oe_d    = ~data_q[7];
                            cnt_d   = 4'd1;
                        end else begin
                            state_d = WR_DATA;
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                        end
                    end
                end
                RD_DATA: begin
                    // cnt counts bits already placed on the bus
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            state_d = ACK_MASTER;
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                        end else begin
                            oe_d  = ~data_q[rd_idx];
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                ACK_MASTER: begin
                    if (scl_rise) begin
                        state_d = WAIT_STOP;
                    end
                end
                WR_DATA: begin
                    if (scl_rise && !cnt_q[3]) begin
                        data_d = {data_q[6:0], sda_in};
                        if (cnt_q == 4'd7) begin
                            cnt_d   = 4'd8;
                            ce_d    = 1'b1;
                            wren_d  = 1'b1;
                            maddr_d = addr_q;
                            wdata_d = {data_q[6:0], sda_in};
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        state_d = ACK_WR;
                        oe_d    = 1'b1;
                        cnt_d   = '0;
                    end
                end
                ACK_WR: begin
                    if (scl_fall) begin
                        state_d = WAIT_STOP;
                        oe_d    = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sda_out           = 1'b0;
    assign sda_oe            = oe_q;
    assign mem_ce            = ce_q;
    assign mem_rden          = rden_q;
    assign mem_wren          = wren_q;
    assign mem_addr          = maddr_q;
    assign mem_wdata         = wdata_q;
    assign slave_state       = state_q;
    assign slave_data        = data_q;
    assign slave_mem_address = addr_q;
    assign slave_select      = sel_q;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Directed bench: bit-banged I2C master plus a small memory model.
module tb_i2c_mem_slave;
    import i2c_pkg::*;

    logic       clk8x = 1'b0;
    logic       reset;
    logic [7:0] id;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_out;
    logic       sda_oe;
    logic       mem_ce;
    logic       mem_rden;
    logic       mem_wren;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [3:0] slave_state;
    logic [7:0] slave_data;
    logic [7:0] slave_mem_address;
    logic [7:0] slave_select;

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int ce_cnt = 0;
    int oe_cnt = 0;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk8x = ~clk8x;

    i2c_mem_slave dut (
        .clk8x             (clk8x),
        .reset             (reset),
        .id                (id),
        .scl               (scl_m),
        .sda_in            (sda_bus),
        .sda_out           (sda_out),
        .sda_oe            (sda_oe),
        .mem_ce            (mem_ce),
        .mem_rden          (mem_rden),
        .mem_wren          (mem_wren),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .slave_state       (slave_state),
        .slave_data        (slave_data),
        .slave_mem_address (slave_mem_address),
        .slave_select      (slave_select)
    );

    always @(posedge clk8x) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else if (mem_ce && mem_wren) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_ce && mem_rden) mem_rdata <= mem[mem_addr];
        if (mem_ce) ce_cnt <= ce_cnt + 1;
        if (mem_rden) begin
            rd_cnt  <= rd_cnt + 1;
            rd_addr <= mem_addr;
        end
        if (mem_wren) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk8x);
            #1;
        end
    endtask

    task automatic bit_clk(input logic b, output logic s);
        tick(2);
        sda_m = b;
        tick(2);
        scl_m = 1'b1;
        tick(2);
        s = sda_bus;
        tick(2);
        scl_m = 1'b0;
    endtask

    task automatic start_c();
        tick(2);
        sda_m = 1'b1;
        tick(2);
        scl_m = 1'b1;
        tick(4);
        sda_m = 1'b0;
        tick(4);
        scl_m = 1'b0;
    endtask

    task automatic stop_c();
        tick(2);
        sda_m = 1'b0;
        tick(2);
        scl_m = 1'b1;
        tick(4);
        sda_m = 1'b1;
        tick(4);
    endtask

    task automatic dev_phase(input logic [7:0] dev, input logic rw,
                             output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_clk(dev[i], s);
        bit_clk(rw, s);
        bit_clk(1'b1, s);
        ack = ~s;
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_clk(b[i], s);
        bit_clk(1'b1, s);
        ack = ~s;
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic nack);
        logic s;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bit_clk(1'b1, s);
            d[i] = s;
        end
        bit_clk(nack, s);
    endtask

    task automatic read_frame(input logic [7:0] dev, input logic [7:0] a,
                              output logic [7:0] d,
                              output logic a1, output logic a2);
        start_c();
        dev_phase(dev, 1'b1, a1);
        wr_byte(a, a2);
        rd_byte(d, 1'b1);
        stop_c();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic       a1, a2, a3;
        int         rd0, wr0, ce0, oe0;

        reset = 1'b1;
        id    = 8'h01;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(4);
        check("rst_state", slave_state, IDLE);
        check("rst_oe", sda_oe, 0);
        check("rst_strobes", {sda_out, mem_ce, mem_rden, mem_wren}, 0);
        check("rst_dbg", {slave_data, slave_mem_address, slave_select}, 0);
        check("rst_mem_bus", {mem_addr, mem_wdata}, 0);
        reset = 1'b0;
        tick(8);

        // Read id 0x01, address 0x05
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        start_c();
        dev_phase(8'h01, 1'b1, a1);
        wr_byte(8'h05, a2);
        rd_byte(d, 1'b1);
        check("rd_ack_dev", a1, 1);
        check("rd_ack_addr", a2, 1);
        check("rd_data", d, 8'h05);
        check("rd_pulses", rd_cnt - rd0, 1);
        check("rd_addr", rd_addr, 8'h05);
        check("rd_no_wr", wr_cnt - wr0, 0);
        check("rd_sel", slave_select, 8'h01);
        check("rd_maddr", slave_mem_address, 8'h05);
        check("rd_wait", slave_state, WAIT_STOP);
        stop_c();
        check("rd_idle", slave_state, IDLE);

        // Write 0xA5 to 0x10, then read it back
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        start_c();
        dev_phase(8'h01, 1'b0, a1);
        wr_byte(8'h10, a2);
        wr_byte(8'hA5, a3);
        stop_c();
        check("wr_acks", {a1, a2, a3}, 3'b111);
        check("wr_pulses", wr_cnt - wr0, 1);
        check("wr_addr", wr_addr, 8'h10);
        check("wr_data", wr_data, 8'hA5);
        check("wr_no_rd", rd_cnt - rd0, 0);
        check("wr_shift", slave_data, 8'hA5);
        read_frame(8'h01, 8'h10, d, a1, a2);
        check("wr_readback", d, 8'hA5);

        // Foreign id: no ACK, no strobes
        ce0 = ce_cnt;
        oe0 = oe_cnt;
        start_c();
        dev_phase(8'h02, 1'b1, a1);
        wr_byte(8'h05, a2);
        check("nid_ack", {a1, a2}, 0);
        check("nid_wait", slave_state, WAIT_STOP);
        stop_c();
        check("nid_idle", slave_state, IDLE);
        check("nid_oe", oe_cnt - oe0, 0);
        check("nid_ce", ce_cnt - ce0, 0);

        // STOP after 3 address bits
        ce0 = ce_cnt;
        start_c();
        dev_phase(8'h01, 1'b1, a1);
        for (int i = 0; i < 3; i++) bit_clk(1'b0, a3);
        tick(2);
        sda_m = 1'b0;
        tick(2);
        scl_m = 1'b1;
        tick(4);
        check("abort_pre", slave_state, MEM_ADDR);
        sda_m = 1'b1;
        tick(1);
        check("abort_idle", slave_state, IDLE);
        tick(4);
        check("abort_ce", ce_cnt - ce0, 0);
        read_frame(8'h01, 8'h07, d, a1, a2);
        check("abort_next", {a1, a2, d}, {2'b11, 8'h07});

        // Repeated START after ACK_ADDR of a write
        wr0 = wr_cnt;
        start_c();
        dev_phase(8'h01, 1'b0, a1);
        wr_byte(8'h20, a2);
        start_c();
        check("rs_state", slave_state, DEV_ADDR);
        dev_phase(8'h01, 1'b1, a1);
        wr_byte(8'h20, a2);
        rd_byte(d, 1'b1);
        stop_c();
        check("rs_no_wr", wr_cnt - wr0, 0);
        check("rs_data", {a1, a2, d}, {2'b11, 8'h20});

        // Reset while driving a 0 data bit
        start_c();
        dev_phase(8'h01, 1'b1, a1);
        wr_byte(8'h05, a2);
        tick(3);
        check("mrst_pre", {slave_state, 3'b000, sda_oe}, {RD_DATA, 4'b0001});
        reset = 1'b1;
        tick(1);
        check("mrst_state", slave_state, IDLE);
        check("mrst_oe", sda_oe, 0);
        check("mrst_strobes", {mem_ce, mem_rden, mem_wren}, 0);
        check("mrst_dbg", {slave_data, slave_mem_address, slave_select}, 0);
        check("mrst_mem_bus", {mem_addr, mem_wdata}, 0);
        reset = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        tick(8);
        read_frame(8'h01, 8'h03, d, a1, a2);
        check("mrst_next", {a1, a2, d}, {2'b11, 8'h03});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
